// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       IorD,
   output logic       MemWrite,
   output logic [1:0] MemOp,
   output logic       MemExt,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [2:0] State,
   output logic       Retire,
   output logic       Illegal,
   output logic       BusErr
);

   localparam logic [5:0] c_op_rtype = 6'h00, c_op_j    = 6'h02, c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04, c_op_bne  = 6'h05, c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_addiu = 6'h09, c_op_slti = 6'h0A, c_op_sltiu = 6'h0B;
   localparam logic [5:0] c_op_andi  = 6'h0C, c_op_ori  = 6'h0D, c_op_xori  = 6'h0E;
   localparam logic [5:0] c_op_lui   = 6'h0F, c_op_lb   = 6'h20, c_op_lh    = 6'h21;
   localparam logic [5:0] c_op_lw    = 6'h23, c_op_lbu  = 6'h24, c_op_lhu   = 6'h25;
   localparam logic [5:0] c_op_sb    = 6'h28, c_op_sh   = 6'h29, c_op_sw    = 6'h2B;

   localparam logic [5:0] c_fn_sll  = 6'h00, c_fn_srl  = 6'h02, c_fn_sra  = 6'h03;
   localparam logic [5:0] c_fn_sllv = 6'h04, c_fn_srlv = 6'h06, c_fn_srav = 6'h07;
   localparam logic [5:0] c_fn_jr   = 6'h08, c_fn_jalr = 6'h09, c_fn_add  = 6'h20;
   localparam logic [5:0] c_fn_addu = 6'h21, c_fn_sub  = 6'h22, c_fn_subu = 6'h23;
   localparam logic [5:0] c_fn_and  = 6'h24, c_fn_or   = 6'h25, c_fn_xor  = 6'h26;
   localparam logic [5:0] c_fn_nor  = 6'h27, c_fn_slt  = 6'h2A, c_fn_sltu = 6'h2B;

   localparam logic [3:0] c_alu_add = 4'd0, c_alu_sub  = 4'd1, c_alu_and = 4'd2;
   localparam logic [3:0] c_alu_or  = 4'd3, c_alu_xor  = 4'd4, c_alu_nor = 4'd5;
   localparam logic [3:0] c_alu_slt = 4'd6, c_alu_sltu = 4'd7, c_alu_sll = 4'd8;
   localparam logic [3:0] c_alu_srl = 4'd9, c_alu_sra  = 4'd10, c_alu_lui = 4'd11;

   localparam logic [1:0] c_mem_word = 2'd0, c_mem_byte = 2'd1, c_mem_half = 2'd2;

   // Last wait cycle allowed before the access is declared dead.
   localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      K_ILL, K_ALUR, K_ALUI, K_LOAD, K_STORE, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR
   } kind_t;

   state_t     r_state, w_next;
   logic [7:0] r_cnt;
   logic       r_illegal, r_buserr;

   kind_t      w_kind;
   logic [3:0] w_aluop;
   logic       w_srca, w_srcb, w_memext;
   logic [1:0] w_memop;

   logic       w_memreq, w_memwrite, w_irwrite, w_pcwrite, w_regwrite, w_retire;
   logic       w_set_ill, w_set_bus, w_last_wait;

   // Instruction classification; OpCode/funct are stable from DECODE onward.
   always_comb begin
      w_kind   = K_ILL;
      w_aluop  = c_alu_add;
      w_srca   = 1'b0;
      w_srcb   = 1'b0;
      w_memop  = c_mem_word;
      w_memext = 1'b0;
      case (OpCode)
         c_op_rtype: begin
            w_kind = K_ALUR;
            case (funct)
               c_fn_sll:  begin w_aluop = c_alu_sll; w_srca = 1'b1; end
               c_fn_srl:  begin w_aluop = c_alu_srl; w_srca = 1'b1; end
               c_fn_sra:  begin w_aluop = c_alu_sra; w_srca = 1'b1; end
               c_fn_sllv: w_aluop = c_alu_sll;
               c_fn_srlv: w_aluop = c_alu_srl;
               c_fn_srav: w_aluop = c_alu_sra;
               c_fn_jr:   w_kind  = K_JR;
               c_fn_jalr: w_kind  = K_JALR;
               c_fn_add, c_fn_addu: w_aluop = c_alu_add;
               c_fn_sub, c_fn_subu: w_aluop = c_alu_sub;
               c_fn_and:  w_aluop = c_alu_and;
               c_fn_or:   w_aluop = c_alu_or;
               c_fn_xor:  w_aluop = c_alu_xor;
               c_fn_nor:  w_aluop = c_alu_nor;
               c_fn_slt:  w_aluop = c_alu_slt;
               c_fn_sltu: w_aluop = c_alu_sltu;
               default:   w_kind  = K_ILL;
            endcase
         end
         c_op_j:   w_kind = K_J;
         c_op_jal: w_kind = K_JAL;
         c_op_beq: begin w_kind = K_BEQ; w_aluop = c_alu_sub; end
         c_op_bne: begin w_kind = K_BNE; w_aluop = c_alu_sub; end
         c_op_addi, c_op_addiu: begin w_kind = K_ALUI; w_aluop = c_alu_add;  w_srcb = 1'b1; end
         c_op_slti:  begin w_kind = K_ALUI; w_aluop = c_alu_slt;  w_srcb = 1'b1; end
         c_op_sltiu: begin w_kind = K_ALUI; w_aluop = c_alu_sltu; w_srcb = 1'b1; end
         c_op_andi:  begin w_kind = K_ALUI; w_aluop = c_alu_and;  w_srcb = 1'b1; end
         c_op_ori:   begin w_kind = K_ALUI; w_aluop = c_alu_or;   w_srcb = 1'b1; end
         c_op_xori:  begin w_kind = K_ALUI; w_aluop = c_alu_xor;  w_srcb = 1'b1; end
         c_op_lui:   begin w_kind = K_ALUI; w_aluop = c_alu_lui;  w_srcb = 1'b1; end
         c_op_lb:  begin w_kind = K_LOAD; w_srcb = 1'b1; w_memop = c_mem_byte; w_memext = 1'b1; end
         c_op_lh:  begin w_kind = K_LOAD; w_srcb = 1'b1; w_memop = c_mem_half; w_memext = 1'b1; end
         c_op_lw:  begin w_kind = K_LOAD; w_srcb = 1'b1; w_memop = c_mem_word; w_memext = 1'b1; end
         c_op_lbu: begin w_kind = K_LOAD; w_srcb = 1'b1; w_memop = c_mem_byte; end
         c_op_lhu: begin w_kind = K_LOAD; w_srcb = 1'b1; w_memop = c_mem_half; end
         c_op_sb:  begin w_kind = K_STORE; w_srcb = 1'b1; w_memop = c_mem_byte; end
         c_op_sh:  begin w_kind = K_STORE; w_srcb = 1'b1; w_memop = c_mem_half; end
         c_op_sw:  begin w_kind = K_STORE; w_srcb = 1'b1; w_memop = c_mem_word; end
         default:  w_kind = K_ILL;
      endcase
   end

   assign w_last_wait = (r_cnt == c_cnt_last) && !MemReady;

   always_comb begin
      w_next     = r_state;
      w_memreq   = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_pcwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_retire   = 1'b0;
      w_set_ill  = 1'b0;
      w_set_bus  = 1'b0;
      IorD       = 1'b0;
      MemOp      = c_mem_word;
      MemExt     = 1'b0;
      PCSrc      = 2'd0;
      RegDst     = 2'd0;
      RegSrc     = 2'd0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 1'b0;
      ALUOp      = c_alu_add;
      case (r_state)
         S_FETCH: begin
            w_memreq = 1'b1;
            if (MemReady) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = S_DECODE;
            end else if (w_last_wait) begin
               w_set_bus = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_DECODE: begin
            case (w_kind)
               K_J, K_JAL, K_JR, K_JALR: begin
                  w_pcwrite = 1'b1;
                  w_retire  = 1'b1;
                  w_next    = S_FETCH;
                  PCSrc     = (w_kind == K_J || w_kind == K_JAL) ? 2'd2 : 2'd3;
                  if (w_kind == K_JAL || w_kind == K_JALR) begin
                     w_regwrite = 1'b1;
                     RegSrc     = 2'd2;
                     RegDst     = (w_kind == K_JAL) ? 2'd2 : 2'd1;
                  end
               end
               K_ILL: begin
                  w_set_ill = 1'b1;
                  w_next    = S_HALT;
               end
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            ALUOp   = w_aluop;
            ALUSrcA = w_srca;
            ALUSrcB = w_srcb;
            case (w_kind)
               K_BEQ, K_BNE: begin
                  PCSrc     = 2'd1;
                  w_pcwrite = (w_kind == K_BEQ) ? Zero : !Zero;
                  w_retire  = 1'b1;
                  w_next    = S_FETCH;
               end
               K_LOAD, K_STORE: w_next = S_MEM;
               default:         w_next = S_WB;
            endcase
         end
         S_MEM: begin
            ALUSrcA    = w_srca;
            ALUSrcB    = w_srcb;
            w_memreq   = 1'b1;
            w_memwrite = (w_kind == K_STORE);
            IorD       = 1'b1;
            MemOp      = w_memop;
            MemExt     = w_memext;
            if (MemReady) begin
               if (w_kind == K_STORE) begin
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_last_wait) begin
               w_set_bus = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_WB: begin
            ALUOp      = w_aluop;
            ALUSrcA    = w_srca;
            ALUSrcB    = w_srcb;
            w_regwrite = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
            if (w_kind == K_LOAD) begin
               RegSrc = 2'd1;
               MemOp  = w_memop;
               MemExt = w_memext;
            end else begin
               RegDst = (w_kind == K_ALUR) ? 2'd1 : 2'd0;
            end
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cnt     <= 8'd0;
         r_illegal <= 1'b0;
         r_buserr  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= 8'd0;
         else if (w_memreq && !MemReady)
            r_cnt <= r_cnt + 8'd1;
         if (w_set_ill)
            r_illegal <= 1'b1;
         if (w_set_bus)
            r_buserr <= 1'b1;
      end
   end

   // Strobes are gated by rst so an in-flight store can never complete a partial write.
   assign MemReq   = w_memreq   & ~rst;
   assign MemWrite = w_memwrite & ~rst;
   assign IRWrite  = w_irwrite  & ~rst;
   assign PCWrite  = w_pcwrite  & ~rst;
   assign RegWrite = w_regwrite & ~rst;
   assign Retire   = w_retire   & ~rst;
   assign State    = r_state;
   assign Illegal  = r_illegal;
   assign BusErr   = r_buserr;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl (TIMEOUT = 4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] OpCode, funct;
   logic       Zero, MemReady;
   logic       MemReq, IorD, MemWrite, MemExt, IRWrite, PCWrite, RegWrite;
   logic       ALUSrcA, ALUSrcB, Retire, Illegal, BusErr;
   logic [1:0] MemOp, PCSrc, RegDst, RegSrc;
   logic [3:0] ALUOp;
   logic [2:0] State;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .OpCode(OpCode), .funct(funct), .Zero(Zero),
      .MemReady(MemReady), .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite),
      .MemOp(MemOp), .MemExt(MemExt), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State),
      .Retire(Retire), .Illegal(Illegal), .BusErr(BusErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Step to just after the next rising edge; inputs are then driven and outputs checked #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] strobes();
      return {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Retire};
   endfunction

   // One zero-wait FETCH cycle carrying the given instruction.
   task automatic fetch0(input logic [5:0] op, input logic [5:0] fn);
      OpCode = op; funct = fn; MemReady = 1'b1; #1;
      chk("fetch_state", State, 3'd0);
      chk("fetch_req", {MemReq, IorD, IRWrite, PCWrite, PCSrc}, 6'b101100);
      tick();
      MemReady = 1'b0;
   endtask

   initial begin
      rst = 1'b1; OpCode = 6'h00; funct = 6'h00; Zero = 1'b0; MemReady = 1'b0;
      tick(); #1;
      chk("rst_state", State, 3'd0);
      chk("rst_strobes", strobes(), 6'b0);
      chk("rst_flags", {Illegal, BusErr}, 2'b0);
      tick();
      rst = 1'b0;

      // ADD, zero-wait: 0,1,2,4
      fetch0(6'h00, 6'h20);
      #1;
      chk("add_dec", {State, RegWrite, Retire}, {3'd1, 2'b00});
      tick(); #1;
      chk("add_exec", {State, ALUOp, ALUSrcA, ALUSrcB, RegWrite}, {3'd2, 4'd0, 3'b000});
      tick(); #1;
      chk("add_wb", {State, RegWrite, RegDst, RegSrc, Retire}, {3'd4, 1'b1, 2'd1, 2'd0, 1'b1});
      tick(); #1;
      chk("add_done", {State, Retire, RegWrite}, {3'd0, 2'b00});

      // LW with two wait cycles in FETCH and in MEM: 9 cycles
      OpCode = 6'h23; funct = 6'h00; MemReady = 1'b0; #1;
      chk("lw_f_wait", {State, MemReq, IRWrite, IorD}, {3'd0, 3'b100});
      tick(); tick();
      MemReady = 1'b1; #1;
      chk("lw_f_ready", IRWrite, 1'b1);
      tick();
      MemReady = 1'b0; #1;
      chk("lw_dec", State, 3'd1);
      tick(); #1;
      chk("lw_exec", {State, ALUSrcB, IorD, ALUOp}, {3'd2, 2'b10, 4'd0});
      tick(); #1;
      chk("lw_mem", {State, MemReq, IorD, MemWrite, ALUOp}, {3'd3, 3'b110, 4'd0});
      tick(); tick();
      MemReady = 1'b1; #1;
      chk("lw_mem_ready", {State, Retire, MemOp, MemExt}, {3'd3, 1'b0, 2'd0, 1'b1});
      tick();
      MemReady = 1'b0; #1;
      chk("lw_wb", {State, RegWrite, RegSrc, RegDst, MemOp, MemExt, IorD, Retire},
          {3'd4, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1});
      tick(); #1;
      chk("lw_done", State, 3'd0);

      // BEQ taken, then BNE not taken, both with Zero=1
      fetch0(6'h04, 6'h00);
      tick();
      Zero = 1'b1; #1;
      chk("beq_exec", {State, PCWrite, PCSrc, Retire, ALUOp}, {3'd2, 1'b1, 2'd1, 1'b1, 4'd1});
      tick(); #1;
      chk("beq_done", State, 3'd0);
      fetch0(6'h05, 6'h00);
      tick(); #1;
      chk("bne_exec", {State, PCWrite, PCSrc, Retire}, {3'd2, 1'b0, 2'd1, 1'b1});
      tick();
      Zero = 1'b0; #1;
      chk("bne_done", State, 3'd0);

      // JAL: two cycles
      fetch0(6'h03, 6'h00);
      #1;
      chk("jal_dec", {State, PCWrite, PCSrc, RegWrite, RegDst, RegSrc, Retire},
          {3'd1, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b1});
      tick(); #1;
      chk("jal_done", State, 3'd0);

      // JR
      fetch0(6'h00, 6'h08);
      #1;
      chk("jr_dec", {PCWrite, PCSrc, RegWrite, Retire}, {1'b1, 2'd3, 1'b0, 1'b1});
      tick(); #1;
      chk("jr_done", State, 3'd0);

      // Fetch ready on the last allowed wait cycle completes normally
      OpCode = 6'h02; funct = 6'h00; MemReady = 1'b0;
      tick(); tick(); tick();
      MemReady = 1'b1; #1;
      chk("edge_ready", {IRWrite, BusErr}, 2'b10);
      tick();
      MemReady = 1'b0; #1;
      chk("edge_dec", {State, BusErr, PCSrc}, {3'd1, 1'b0, 2'd2});
      tick(); #1;
      chk("edge_done", State, 3'd0);

      // Illegal opcode halts until reset
      fetch0(6'h3F, 6'h00);
      #1;
      chk("ill_dec", {State, strobes(), Illegal}, {3'd1, 6'b0, 1'b0});
      tick(); #1;
      chk("ill_halt", {State, Illegal}, {3'd5, 1'b1});
      for (int i = 0; i < 20; i++) begin
         MemReady = i[0]; #1;
         chk("ill_hold", {State, strobes()}, {3'd5, 6'b0});
         tick();
      end
      rst = 1'b1; #1;
      chk("ill_rst", {State, Illegal}, {3'd0, 1'b0});
      tick();
      rst = 1'b0; MemReady = 1'b0;

      // SW with memory stuck in MEM: bus error after 4 wait cycles
      fetch0(6'h2B, 6'h00);
      tick(); #1;
      chk("sw_exec", {State, ALUSrcB}, {3'd2, 1'b1});
      tick(); #1;
      chk("sw_mem", {State, MemReq, MemWrite, IorD, MemOp}, {3'd3, 3'b111, 2'd0});
      tick(); tick(); tick(); #1;
      chk("sw_w4", {State, MemReq, BusErr}, {3'd3, 1'b1, 1'b0});
      tick(); #1;
      chk("sw_buserr", {State, MemReq, BusErr, MemWrite}, {3'd5, 1'b0, 1'b1, 1'b0});
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // SW again, reset mid-MEM
      fetch0(6'h2B, 6'h00);
      tick(); tick(); #1;
      chk("sw2_mem", {State, MemWrite}, {3'd3, 1'b1});
      rst = 1'b1; #1;
      chk("sw2_rst", {State, MemWrite, MemReq, BusErr}, {3'd0, 3'b000});
      tick();
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
